// File: rtl/scoreboard.sv
// scoreboard: 32-entry register-status scoreboard.
// Each entry holds the producing unit and a one-hot row that counts the
// cycles until the result reaches writeback. The entry is pending while
// its row is non-zero. One write port and two combinational read ports.
// Optional feature: define SCOREBOARD_ZERO_REG_EN to hard-wire register 0
// as never pending, like MIPS $zero.
module scoreboard (
   input  logic       clock,
   input  logic       reset,
   input  logic [4:0] ass_addr_a,
   output logic       ass_pending_a,
   output logic [1:0] ass_unit_a,
   output logic [4:0] ass_row_a,
   input  logic [4:0] ass_addr_b,
   output logic       ass_pending_b,
   output logic [1:0] ass_unit_b,
   output logic [4:0] ass_row_b,
   input  logic [1:0] registerunit,
   input  logic [4:0] writeaddr_a,
   input  logic       enablewrite_a
);

   logic [1:0] unit_q [32];
   logic [4:0] row_q  [32];
   logic [4:0] load_row;
   logic       write_ok;

   // Initial row for the unit being issued: bit (latency-1) set.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      load_row = 5'b00010;
      unique case (registerunit)
         2'd0:    load_row = 5'b00001;  // ALU, latency 1
         2'd1:    load_row = 5'b01000;  // memory, latency 4
         2'd2:    load_row = 5'b10000;  // multiply, latency 5
         default: load_row = 5'b00010;  // branch/misc, latency 2
      endcase
   end

   // Qualify the write strobe; register 0 may be read-only.
   always_comb begin
`ifdef SCOREBOARD_ZERO_REG_EN
      write_ok = enablewrite_a && (writeaddr_a != 5'd0);
`else
      write_ok = enablewrite_a;
`endif
   end

   // Entry update: a write reloads its entry, every other row shifts toward writeback.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         // NOTE: the entry array is reset explicitly because pending is derived from row contents.
         for (int i = 0; i < 32; i++) begin
            unit_q[i] <= 2'd0;
            row_q[i]  <= 5'd0;
         end
      end else begin
         // NOTE: non-blocking assignments so every entry updates from pre-edge state.
         for (int i = 0; i < 32; i++) begin
            if (write_ok && (writeaddr_a == 5'(i))) begin
               unit_q[i] <= registerunit;
               row_q[i]  <= load_row;
            end else begin
               row_q[i]  <= row_q[i] >> 1;
            end
         end
      end
   end

   // Read port A: combinational view of the current state, no write bypass.
   always_comb begin
      ass_unit_a = unit_q[ass_addr_a];
      ass_row_a  = row_q[ass_addr_a];
`ifdef SCOREBOARD_ZERO_REG_EN
      if (ass_addr_a == 5'd0) begin
         ass_unit_a = 2'd0;
         ass_row_a  = 5'd0;
      end
`endif
      ass_pending_a = |ass_row_a;
   end

   // Read port B: independent copy of port A.
   always_comb begin
      ass_unit_b = unit_q[ass_addr_b];
      ass_row_b  = row_q[ass_addr_b];
`ifdef SCOREBOARD_ZERO_REG_EN
      if (ass_addr_b == 5'd0) begin
         ass_unit_b = 2'd0;
         ass_row_b  = 5'd0;
      end
`endif
      ass_pending_b = |ass_row_b;
   end

endmodule

// File: tb/tb_scoreboard.sv
// tb_scoreboard: directed and randomized checks of the scoreboard against a
// count-down model (remaining writeback cycles per register).
`timescale 1ns/1ps
module tb_scoreboard;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [4:0] ass_addr_a = '0;
   logic       ass_pending_a;
   logic [1:0] ass_unit_a;
   logic [4:0] ass_row_a;
   logic [4:0] ass_addr_b = '0;
   logic       ass_pending_b;
   logic [1:0] ass_unit_b;
   logic [4:0] ass_row_b;
   logic [1:0] registerunit = '0;
   logic [4:0] writeaddr_a = '0;
   logic       enablewrite_a = 1'b0;

   int checks = 0;
   int failures = 0;

   // Model: cycles remaining until writeback, and last unit written.
   int         cnt   [32];
   logic [1:0] munit [32];

   logic [7:0] got;
   logic [7:0] exp;

   scoreboard dut (
      .clock         (clock),
      .reset         (reset),
      .ass_addr_a    (ass_addr_a),
      .ass_pending_a (ass_pending_a),
      .ass_unit_a    (ass_unit_a),
      .ass_row_a     (ass_row_a),
      .ass_addr_b    (ass_addr_b),
      .ass_pending_b (ass_pending_b),
      .ass_unit_b    (ass_unit_b),
      .ass_row_b     (ass_row_b),
      .registerunit  (registerunit),
      .writeaddr_a   (writeaddr_a),
      .enablewrite_a (enablewrite_a)
   );

   always #5 clock = ~clock;

   function automatic int latency(input logic [1:0] u);
      case (u)
         2'd0:    return 1;
         2'd1:    return 4;
         2'd2:    return 5;
         default: return 2;
      endcase
   endfunction

   // Expected {pending, unit, row} for a register from the model.
   function automatic logic [7:0] model_view(input logic [4:0] a);
      int c;
      logic [4:0] r;
      c = cnt[a];
      r = (c == 0) ? 5'd0 : 5'(1 << (c - 1));
      return {(c != 0), munit[a], r};
   endfunction

   function automatic logic [7:0] view_a();
      return {ass_pending_a, ass_unit_a, ass_row_a};
   endfunction

   function automatic logic [7:0] view_b();
      return {ass_pending_b, ass_unit_b, ass_row_b};
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 32; i++) begin
         cnt[i]   = 0;
         munit[i] = 2'd0;
      end
   endtask

   // One clock edge with the given write; model advanced; returns 1ns after the edge.
   task automatic step(input logic we, input logic [4:0] wa, input logic [1:0] u);
      bit discard;
      enablewrite_a = we;
      writeaddr_a   = wa;
      registerunit  = u;
      @(posedge clock);
`ifdef SCOREBOARD_ZERO_REG_EN
      discard = (wa == 5'd0);
`else
      discard = 1'b0;
`endif
      for (int i = 0; i < 32; i++) begin
         if (we && !discard && (wa == 5'(i))) begin
            cnt[i]   = latency(u);
            munit[i] = u;
         end else if (cnt[i] > 0) begin
            cnt[i]--;
         end
      end
      #1;
      enablewrite_a = 1'b0;
   endtask

   task automatic test_reset();
      logic [4:0] addrs [3];
      addrs[0] = 5'd0; addrs[1] = 5'd4; addrs[2] = 5'd31;
      step(1'b1, 5'd4, 2'd2);
      step(1'b1, 5'd31, 2'd1);
      reset = 1'b0;
      model_clear();
      for (int k = 0; k < 3; k++) begin
         ass_addr_a = addrs[k];
         ass_addr_b = addrs[k];
         #1;
         got = view_a();
         checks++;
         if (got !== 8'h00) begin
            failures++;
            $display("FAIL reset_a addr %0d: got %b expected %b", addrs[k], got, 8'h00);
         end
         got = view_b();
         checks++;
         if (got !== 8'h00) begin
            failures++;
            $display("FAIL reset_b addr %0d: got %b expected %b", addrs[k], got, 8'h00);
         end
      end
      // A write strobe while reset is held must be ignored.
      enablewrite_a = 1'b1;
      writeaddr_a   = 5'd4;
      registerunit  = 2'd1;
      ass_addr_a    = 5'd4;
      @(posedge clock);
      #1;
      got = view_a();
      checks++;
      if (got !== 8'h00) begin
         failures++;
         $display("FAIL reset_held_write: got %b expected %b", got, 8'h00);
      end
      enablewrite_a = 1'b0;
      reset = 1'b1;
   endtask

   task automatic test_memory_write();
      logic [4:0] rows [5];
      rows[0] = 5'b01000; rows[1] = 5'b00100; rows[2] = 5'b00010;
      rows[3] = 5'b00001; rows[4] = 5'b00000;
      ass_addr_a = 5'd4;
      step(1'b1, 5'd4, 2'd1);
      for (int k = 0; k < 5; k++) begin
         if (k > 0) step(1'b0, 5'd0, 2'd0);
         exp = {(rows[k] != 5'd0), 2'd1, rows[k]};
         got = view_a();
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL mem_write edge %0d: got %b expected %b", k, got, exp);
         end
      end
   endtask

   task automatic test_rewrite();
      ass_addr_a = 5'd7;
      step(1'b1, 5'd7, 2'd2);
      got = view_a();
      checks++;
      if (got !== {1'b1, 2'd2, 5'b10000}) begin
         failures++;
         $display("FAIL rewrite_first: got %b expected %b", got, {1'b1, 2'd2, 5'b10000});
      end
      step(1'b0, 5'd0, 2'd0);
      step(1'b0, 5'd0, 2'd0);
      step(1'b1, 5'd7, 2'd0);
      got = view_a();
      checks++;
      if (got !== {1'b1, 2'd0, 5'b00001}) begin
         failures++;
         $display("FAIL rewrite_reload: got %b expected %b", got, {1'b1, 2'd0, 5'b00001});
      end
      step(1'b0, 5'd0, 2'd0);
      got = view_a();
      checks++;
      if (got !== 8'h00) begin
         failures++;
         $display("FAIL rewrite_clear: got %b expected %b", got, 8'h00);
      end
   endtask

   task automatic test_dual_read();
      ass_addr_a = 5'd3;
      ass_addr_b = 5'd9;
      step(1'b1, 5'd3, 2'd3);
      step(1'b1, 5'd9, 2'd1);
      for (int k = 0; k < 6; k++) begin
         if (k > 0) step(1'b0, 5'd0, 2'd0);
         exp = model_view(5'd3);
         got = view_a();
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL dual_a edge %0d: got %b expected %b", k, got, exp);
         end
         exp = model_view(5'd9);
         got = view_b();
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL dual_b edge %0d: got %b expected %b", k, got, exp);
         end
      end
      ass_addr_b = 5'd20;
      #1;
      got = view_b();
      checks++;
      if (got[7] !== 1'b0) begin
         failures++;
         $display("FAIL dual_third: got pending %b expected 0", got[7]);
      end
   endtask

   task automatic test_async_reset();
      ass_addr_a = 5'd4;
      step(1'b1, 5'd4, 2'd1);
      step(1'b0, 5'd0, 2'd0);
      got = view_a();
      checks++;
      if (got !== {1'b1, 2'd1, 5'b00100}) begin
         failures++;
         $display("FAIL async_pre: got %b expected %b", got, {1'b1, 2'd1, 5'b00100});
      end
      reset = 1'b0;
      #1;
      got = view_a();
      checks++;
      if (got !== 8'h00) begin
         failures++;
         $display("FAIL async_reset: got %b expected %b", got, 8'h00);
      end
      model_clear();
      #1;
      reset = 1'b1;
   endtask

   task automatic test_zero_reg();
      ass_addr_a = 5'd0;
      step(1'b1, 5'd0, 2'd1);
`ifdef SCOREBOARD_ZERO_REG_EN
      exp = 8'h00;
`else
      exp = {1'b1, 2'd1, 5'b01000};
`endif
      got = view_a();
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL zero_reg: got %b expected %b", got, exp);
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         ass_addr_a = 5'($urandom_range(0, 31));
         ass_addr_b = ($urandom_range(0, 3) == 0) ? ass_addr_a : 5'($urandom_range(0, 31));
         step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
         exp = model_view(ass_addr_a);
         got = view_a();
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL random_a cycle %0d addr %0d: got %b expected %b", k, ass_addr_a, got, exp);
         end
         exp = model_view(ass_addr_b);
         got = view_b();
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL random_b cycle %0d addr %0d: got %b expected %b", k, ass_addr_b, got, exp);
         end
      end
   endtask

   initial begin
      model_clear();
      reset = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b1;
      test_reset();
      test_memory_write();
      test_rewrite();
      test_dual_read();
      test_async_reset();
      test_zero_reg();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
